instruction_fetch_stage: RTL

Front end of the RV32 pipeline: owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers the returned words in a 2-entry queue. The queue delivers {instruction, pc} pairs to the decode stage over a valid/ready handshake. Later stages flush it and retarget it with a single-cycle redirect.

---
 rtl/rv32_pipeline_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types and constants.
//   fetch_entry_t    : {instruction, pc} pair handed from fetch to decode
//   INSTR_BYTES      : fetch address increment
//   FETCH_FIFO_DEPTH : fetch buffer entries (must be a power of two)
//   RESET_VECTOR_DEFAULT : default PC after reset
package rv32_pipeline_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W       = $clog2(FETCH_FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W       = $clog2(FETCH_FIFO_DEPTH + 1);

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t with flush and same-cycle push/pop.
//   clk, rst     : clock, synchronous active-high reset (clears storage too)
//   flush_i      : empty the queue; overrides push/pop
//   push_i       : write push_data_i at the tail
//   pop_i        : retire the head
//   head_o       : current head entry (stale contents when count_o == 0)
//   count_o      : number of valid entries
module fetch_fifo
  import rv32_pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  fetch_entry_t          push_data_i,
  input  logic                  pop_i,
  output fetch_entry_t          head_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  fetch_entry_t          mem_q [FETCH_FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  // Pointer/count update; pointers wrap naturally because depth is a power of two.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FIFO_CNT_W'(FETCH_FIFO_DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
      count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues one-at-a-time word reads to
// instruction memory and buffers returned words for decode.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/ready/addr         : fetch request channel (addr word aligned)
//   imem_rsp_valid/data               : in-order read data, one per accepted request
//   redirect_valid/pc                 : flush and restart fetch at redirect_pc & ~3
//   id_valid/ready/instruction/pc     : {instruction, pc} handshake to decode
module instruction_fetch_stage
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           req_pc_q, req_pc_d;
  logic                  outstanding_q, outstanding_d;
  logic                  drop_pending_q, drop_pending_d;
  logic [FIFO_CNT_W-1:0] fifo_count;
  fetch_entry_t          fifo_head, fifo_push_data;
  logic                  id_fire, rsp_fire, req_fire, fifo_push, fifo_pop, slot_free;
  logic [OCC_W-1:0]      occupancy;

  // Request gating. The word in flight (arriving now or later) already owns a
  // buffer slot, and a same-cycle decode pop frees one. A drop_pending request
  // is always outstanding, so the outstanding term also holds off fetch until
  // the stale word returns, and that return cycle may issue the new request.
  always_comb begin
    id_fire        = id_valid && id_ready;
    rsp_fire       = imem_rsp_valid && outstanding_q;
    occupancy      = OCC_W'(fifo_count) + OCC_W'(outstanding_q);
    slot_free      = occupancy < (OCC_W'(FETCH_FIFO_DEPTH) + OCC_W'(id_fire));
    imem_req_valid = !rst && (!outstanding_q || imem_rsp_valid) && slot_free;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Next-state for PC and in-flight tracking; redirect has priority.
  always_comb begin
    fifo_push                  = rsp_fire && !drop_pending_q && !redirect_valid;
    fifo_pop                   = id_fire && !redirect_valid;
    fifo_push_data.instruction = imem_rsp_data;
    fifo_push_data.pc          = req_pc_q;
    fetch_pc_d                 = fetch_pc_q;
    req_pc_d                   = req_pc_q;
    outstanding_d              = outstanding_q;
    drop_pending_d             = drop_pending_q;
    if (rsp_fire) begin
      outstanding_d  = 1'b0;
      drop_pending_d = 1'b0;
    end
    if (req_fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'(INSTR_BYTES);
    end
    if (redirect_valid) begin
      fetch_pc_d     = redirect_pc & ~32'h3;
      drop_pending_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= RESET_VECTOR & ~32'h3;
      req_pc_q       <= '0;
      outstanding_q  <= 1'b0;
      drop_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      outstanding_q  <= outstanding_d;
      drop_pending_q <= drop_pending_d;
    end
  end

  fetch_fifo u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign imem_req_addr  = fetch_pc_q;
  assign id_valid       = (fifo_count != '0);
  assign id_instruction = fifo_head.instruction;
  assign id_pc          = fifo_head.pc;

endmodule
